accum_datapath: RTL

//  Execution datapath driven by the accumulator-CPU Controller. It holds the PC, IR,

---
 rtl/accum_datapath.sv | 133 +++++++++++++
 1 files changed

// File: rtl/accum_datapath.sv
// Accumulator-CPU execution datapath: PC, IR, register file, accumulator, ALU and flag.
// Optional build macro REG0_ZERO_EN: register 0 is hardwired to zero.
module accum_datapath #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              LoadIR,
  input  logic              IncPC,
  input  logic              SelPC,
  input  logic              LoadPC,
  input  logic              LoadReg,
  input  logic              DumpReg,
  input  logic              LoadAcc,
  input  logic              DumpAcc,
  input  logic              SelAcc0,
  input  logic              SelAcc1,
  input  logic [3:0]        SelALU,
  input  logic [3:0]        RegNumber,
  input  logic [7:0]        imem_data,
  output logic [PC_W-1:0]   imem_addr,
  output logic [7:0]        Opcode,
  output logic              Zero_Carry,
  output logic [DATA_W-1:0] acc_out
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_NOR = 4'b1000,
    ALU_SHR = 4'b1100,
    ALU_SHL = 4'b1101
  } alu_op_e;

  logic [PC_W-1:0]   pc;
  logic [7:0]        ir;
  logic [DATA_W-1:0] acc;
  logic              f;
  logic [DATA_W-1:0] regs [NREGS];

  logic [DATA_W-1:0] imm_d;
  logic [PC_W-1:0]   imm_pc;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] alu_a, alu_b, alu_r;
  logic              alu_c;
  logic [DATA_W-1:0] acc_next;
  logic              reg_we;
  logic [DATA_W-1:0] reg_wdata;

  assign imm_d  = DATA_W'(ir[3:0]);
  assign imm_pc = PC_W'(ir[3:0]);

  always_comb begin
    rd_data = regs[RegNumber];
`ifdef REG0_ZERO_EN
    if (RegNumber == '0) rd_data = '0;
`endif
  end

  assign alu_a = acc;
  assign alu_b = DumpReg ? rd_data : '0;

  always_comb begin
    alu_r = alu_a;
    alu_c = 1'b0;
    case (SelALU)
      ALU_ADD: {alu_c, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_SUB: begin
        alu_r = alu_a - alu_b;
        alu_c = (alu_a < alu_b);
      end
      ALU_NOR: alu_r = ~(alu_a | alu_b);
      ALU_SHR: begin
        alu_r = alu_a >> 1;
        alu_c = alu_a[0];
      end
      ALU_SHL: begin
        alu_r = alu_a << 1;
        alu_c = alu_a[DATA_W-1];
      end
      default: begin
        alu_r = alu_a;
        alu_c = 1'b0;
      end
    endcase
  end

  always_comb begin
    case ({SelAcc1, SelAcc0})
      2'b00:   acc_next = imm_d;
      2'b01:   acc_next = rd_data;
      default: acc_next = alu_r;
    endcase
  end

  // DumpAcc takes the pre-update acc, so a same-cycle LoadAcc swaps cleanly.
  always_comb begin
    reg_wdata = DumpAcc ? acc : imm_d;
    reg_we    = DumpAcc | LoadReg;
`ifdef REG0_ZERO_EN
    if (RegNumber == '0) reg_we = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= '0;
      ir  <= '0;
      acc <= '0;
      f   <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (LoadPC)
        pc <= SelPC ? imm_pc : PC_W'(rd_data);
      else if (IncPC)
        pc <= pc + 1'b1;
      if (LoadIR) ir <= imem_data;
      if (LoadAcc) begin
        acc <= acc_next;
        if (SelAcc1) f <= alu_c;
      end
      if (reg_we) regs[RegNumber] <= reg_wdata;
    end
  end

  assign imem_addr  = pc;
  assign Opcode     = ir;
  assign Zero_Carry = f;
  assign acc_out    = acc;

endmodule
